sram_pixel_writer: RTL and testbench
====================================

Name: sram_pixel_writer

Overview:
- Write-side counterpart of the display read path. Takes processed RGB555 pixels from the image pipeline and buffers them in a small FIFO.
- Writes each pixel as one 16-bit word into the frame buffer in external SRAM, in raster order from address 0.
- Yields the SRAM to the display reader whenever the reader claims the bus. Signals completion once a full frame has been written.

Parameters:
- H_ACT, 640, active pixels per line
- V_ACT, 480, active lines per frame
- FIFO_DEPTH, 4, pixel buffer entries (power of two, >=2)
- ADDR_W, 20, SRAM word-address width

Ports:
- i_clk  in  1  system clock; all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_frame_start  in  1  one-cycle pulse; starts or restarts a frame write
- i_pix_valid  in  1  pixel present on i_pix_data
- i_pix_data  in  15  {R[4:0],G[4:0],B[4:0]}
- o_pix_ready  out  1  pixel accepted when valid && ready
- i_rd_busy  in  1  display reader owns the SRAM this cycle
- o_s_data  out  16  SRAM write data
- o_s_wen  out  1  SRAM write enable, active-low (0 = write this cycle)
- o_s_addr  out  ADDR_W  SRAM word address
- o_frame_done  out  1  one-cycle pulse after the last pixel of a frame is written

Behaviour:
- Reset (async, i_rst_n=0):
  - State IDLE; FIFO empty; accept and write counters 0.
  - o_s_wen=1, o_s_addr=0, o_s_data=0, o_frame_done=0.
  - A reset in the middle of a frame abandons it; no partial-frame done pulse.
- Constant: TOTAL = H_ACT*V_ACT, sized to ADDR_W bits. TOTAL must be <= 2^ADDR_W.
- FSM states:
  - IDLE: o_pix_ready=0. i_frame_start -> WRITE; clears counters and FIFO.
  - WRITE: accepts pixels and drains the FIFO to SRAM. When the write counter reaches TOTAL -> DONE.
  - DONE: o_frame_done=1 for exactly this one cycle -> IDLE. i_frame_start here -> WRITE; the done pulse is still emitted.
- o_pix_ready = (state==WRITE) && !fifo_full && (acc_cnt < TOTAL) && !i_frame_start. This is the only combinational output.
- Accept: on valid && ready, push i_pix_data and increment acc_cnt. Pixels offered while ready=0 are not consumed; the upstream holds them.
- SRAM write:
  - Condition: in WRITE, FIFO non-empty, and i_rd_busy=0.
  - Next cycle, registered: o_s_wen=0, o_s_addr=wr_cnt, o_s_data={1'b0, fifo_head}. The head is popped and wr_cnt increments.
  - In every other cycle: o_s_wen=1, and o_s_addr/o_s_data hold their last values.
- Latency: a pixel accepted at edge N into an empty FIFO, with i_rd_busy=0, appears as o_s_wen=0 in cycle N+1.
- Throughput: one write per cycle while the FIFO is non-empty and the bus is free. Push and pop in the same cycle leave the FIFO occupancy unchanged and are legal when the FIFO is full.
- i_rd_busy=1 stalls writes only. Acceptance continues until the FIFO is full.
- i_frame_start while in WRITE restarts the frame:
  - FIFO flushed, counters cleared to 0, state stays WRITE.
  - Any write scheduled for that edge is suppressed (o_s_wen=1 next cycle).
  - Pixel not accepted that cycle.
- Final pixel: the write with wr_cnt=TOTAL-1 issues normally. The FSM enters DONE on that same edge, so o_frame_done is high in the cycle o_s_wen=0 shows the last address.
- Address progression: no wrap inside a frame. The address returns to 0 only on i_frame_start.

Decomposition:
- Shared package sram_pkg:
  - typedef pix555_t (15 bits)
  - typedef sram_word_t (16 bits)
  - state enum {IDLE, WRITE, DONE}
  - function pack555(pix) returning {1'b0, pix}
- Sub-module sync_fifo:
  - Parameters WIDTH, DEPTH.
  - Ports: push, pop, din, dout (head, first-word-fall-through), full, empty, flush.
  - Same clock and async active-low reset as the parent.

Test Plan (H_ACT=4, V_ACT=2, FIFO_DEPTH=4):
- Reset mid-frame, then release -> o_s_wen=1, o_s_addr=0, o_pix_ready=0, o_frame_done=0. No writes until i_frame_start.
- Frame start, then 8 back-to-back valid pixels 0x7C00..0x7C07 with i_rd_busy=0 -> 8 consecutive o_s_wen=0 cycles at addresses 0..7 carrying data 0x7C00..0x7C07. The first write occurs one cycle after the first accept. o_frame_done pulses in the cycle of address 7. o_pix_ready=0 afterwards.
- i_rd_busy=1 held for 10 cycles with continuous valid -> exactly 4 pixels accepted, then ready=0 and no writes. On release, 4 writes in consecutive cycles at addresses 0..3; acceptance resumes.
- Mid-frame restart: after 3 writes, pulse i_frame_start with a full FIFO -> the next write is at address 0 with the first new pixel. Old FIFO contents are never written.
- Pixel valid in IDLE with no frame start -> o_pix_ready=0 and o_s_wen stays 1 for 20 cycles.
- i_frame_start coincident with the DONE cycle -> o_frame_done=1 for that cycle, FSM in WRITE, next frame writes begin at address 0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types for the SRAM pixel write path: pixel/word types, writer FSM states.
package sram_pkg;

  localparam int unsigned PIX_W  = 15;
  localparam int unsigned WORD_W = 16;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } pix555_t;

  typedef logic [WORD_W-1:0] sram_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // RGB555 pixel into a 16-bit SRAM word; top bit unused.
  function automatic sram_word_t pack555(input pix555_t pix);
    return {1'b0, pix};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO with synchronous flush.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sram_pixel_writer.sv
// Buffers RGB555 pixels and writes one frame in raster order to SRAM,
// yielding the bus to the display reader whenever it is busy.
module sram_pixel_writer
  import sram_pkg::*;
#(
  parameter int unsigned H_ACT      = 640,
  parameter int unsigned V_ACT      = 480,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_start,
  input  logic              i_pix_valid,
  input  logic [14:0]       i_pix_data,
  output logic              o_pix_ready,
  input  logic              i_rd_busy,
  output logic [15:0]       o_s_data,
  output logic              o_s_wen,
  output logic [ADDR_W-1:0] o_s_addr,
  output logic              o_frame_done
);

  // One spare bit so a frame filling the whole address space still compares cleanly.
  localparam int unsigned      CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(H_ACT * V_ACT);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] wr_cnt;
  logic             wr_go;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  pix555_t          fifo_head;

  assign push = i_pix_valid && o_pix_ready;

  sync_fifo #(
    .WIDTH ($bits(pix555_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (push),
    .pop     (wr_go),
    .flush   (i_frame_start),
    .din     (i_pix_data),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state, accept handshake and write decision; frame start pre-empts both.
  always_comb begin
    state_d     = state_q;
    o_pix_ready = 1'b0;
    wr_go       = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_frame_start) state_d = WRITE;
      end
      WRITE: begin
        o_pix_ready = !fifo_full && (acc_cnt < TOTAL) && !i_frame_start;
        wr_go       = !fifo_empty && !i_rd_busy && !i_frame_start;
        if (wr_go && (wr_cnt == TOTAL - CNT_W'(1))) state_d = DONE;
      end
      DONE: begin
        state_d = i_frame_start ? WRITE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else if (i_frame_start) begin
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      if (push)  acc_cnt <= acc_cnt + CNT_W'(1);
      if (wr_go) wr_cnt  <= wr_cnt + CNT_W'(1);
    end
  end

  // SRAM bus: address and data hold between writes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_s_wen      <= 1'b1;
      o_s_addr     <= '0;
      o_s_data     <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_s_wen      <= !wr_go;
      o_frame_done <= (state_d == DONE);
      if (wr_go) begin
        o_s_addr <= wr_cnt[ADDR_W-1:0];
        o_s_data <= pack555(fifo_head);
      end
    end
  end

endmodule

// File: tb/tb_sram_pixel_writer.sv
// Self-checking bench for sram_pixel_writer against a queue-based frame model.
module tb_sram_pixel_writer;

  localparam int H_ACT = 4;
  localparam int V_ACT = 2;
  localparam int DEPTH = 4;
  localparam int TOTAL = H_ACT * V_ACT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_frame_start;
  logic        i_pix_valid;
  logic [14:0] i_pix_data;
  logic        i_rd_busy;
  logic        o_pix_ready;
  logic [15:0] o_s_data;
  logic        o_s_wen;
  logic [19:0] o_s_addr;
  logic        o_frame_done;

  int total = 0;
  int bad   = 0;

  // Model: frame active flag, pending pixel queue, accept/write counts.
  logic        m_active;
  logic [14:0] m_q[$];
  int          m_acc;
  int          m_wr;

  logic        e_rdy, e_wen, e_done;
  logic [19:0] e_addr;
  logic [15:0] e_data;
  logic        s_rdy, s_wen, s_done;
  logic [19:0] s_addr;
  logic [15:0] s_data;

  always #5 clk = ~clk;

  sram_pixel_writer #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .FIFO_DEPTH(DEPTH), .ADDR_W(20)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_frame_start(i_frame_start),
    .i_pix_valid  (i_pix_valid),
    .i_pix_data   (i_pix_data),
    .o_pix_ready  (o_pix_ready),
    .i_rd_busy    (i_rd_busy),
    .o_s_data     (o_s_data),
    .o_s_wen      (o_s_wen),
    .o_s_addr     (o_s_addr),
    .o_frame_done (o_frame_done)
  );

  task automatic model_reset();
    m_active = 1'b0;
    m_q.delete();
    m_acc = 0;
    m_wr  = 0;
    e_rdy = 1'b0; e_wen = 1'b1; e_done = 1'b0;
    e_addr = '0;  e_data = '0;
  endtask

  // Drive one cycle, advance the model, sample ready before and bus after the edge.
  task automatic cyc(input logic fs, input logic vld, input logic [14:0] pix, input logic busy);
    logic        do_wr;
    logic [14:0] head;
    i_frame_start = fs; i_pix_valid = vld; i_pix_data = pix; i_rd_busy = busy;
    @(negedge clk);
    s_rdy  = o_pix_ready;
    e_rdy  = m_active && (m_q.size() < DEPTH) && (m_acc < TOTAL) && !fs;
    do_wr  = m_active && (m_q.size() > 0) && !busy && !fs;
    e_wen  = 1'b1;
    e_done = 1'b0;
    if (do_wr) begin
      head   = m_q.pop_front();
      e_wen  = 1'b0;
      e_addr = 20'(m_wr);
      e_data = {1'b0, head};
      m_wr++;
      if (m_wr == TOTAL) begin
        e_done   = 1'b1;
        m_active = 1'b0;
      end
    end
    if (vld && e_rdy) begin
      m_q.push_back(pix);
      m_acc++;
    end
    if (fs) begin
      m_q.delete();
      m_acc = 0;
      m_wr  = 0;
      m_active = 1'b1;
    end
    @(posedge clk);
    #1;
    s_wen = o_s_wen; s_addr = o_s_addr; s_data = o_s_data; s_done = o_frame_done;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 15'h0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 15'h1230 + 15'(i), 1'b0);
    i_pix_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({o_s_wen, o_pix_ready, o_frame_done} !== 3'b100) begin
      bad++;
      $display("FAIL reset_ctl wen/rdy/done got=%b%b%b exp=100", o_s_wen, o_pix_ready, o_frame_done);
    end
    total++;
    if ({o_s_addr, o_s_data} !== 36'h0) begin
      bad++;
      $display("FAIL reset_bus addr=%h data=%h exp 0/0", o_s_addr, o_s_data);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 15'(32'($urandom)), 1'b0);
      total++;
      if ({s_rdy, s_wen, s_done} !== 3'b010) begin
        bad++;
        $display("FAIL reset_after cyc=%0d rdy/wen/done got=%b%b%b exp=010", i, s_rdy, s_wen, s_done);
      end
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 15'(32'($urandom)), 1'b0);
      total++;
      if ({s_rdy, s_wen} !== 2'b01) begin
        bad++;
        $display("FAIL idle cyc=%0d rdy/wen got=%b%b exp=01", i, s_rdy, s_wen);
      end
    end
  endtask

  task automatic test_back_to_back();
    int first_acc, first_wr, n_wr;
    first_acc = -1; first_wr = -1; n_wr = 0;
    cyc(1'b1, 1'b0, 15'h0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (i < TOTAL) cyc(1'b0, 1'b1, 15'h7C00 + 15'(i), 1'b0);
      else           cyc(1'b0, 1'b0, 15'h0, 1'b0);
      if (first_acc < 0 && s_rdy && i < TOTAL) first_acc = i;
      total++;
      if ({s_rdy, s_wen, s_done} !== {e_rdy, e_wen, e_done}) begin
        bad++;
        $display("FAIL b2b_ctl cyc=%0d rdy/wen/done got=%b%b%b exp=%b%b%b",
                 i, s_rdy, s_wen, s_done, e_rdy, e_wen, e_done);
      end
      total++;
      if ({s_addr, s_data} !== {e_addr, e_data}) begin
        bad++;
        $display("FAIL b2b_bus cyc=%0d addr=%h data=%h exp=%h/%h", i, s_addr, s_data, e_addr, e_data);
      end
      if (!s_wen) begin
        if (first_wr < 0) first_wr = i;
        total++;
        if (s_addr !== 20'(n_wr) || s_data !== 16'h7C00 + 16'(n_wr) || s_done !== (n_wr == TOTAL-1)) begin
          bad++;
          $display("FAIL b2b_seq n=%0d addr=%h data=%h done=%b", n_wr, s_addr, s_data, s_done);
        end
        n_wr++;
      end
    end
    total++;
    if (n_wr != TOTAL || first_wr != first_acc + 1 || s_rdy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_summary writes=%0d first_wr=%0d first_acc=%0d rdy=%b exp %0d/acc+1/0",
               n_wr, first_wr, first_acc, s_rdy, TOTAL);
    end
  endtask

  task automatic test_busy_stall();
    int n_a, n_w, n_a2;
    n_a = 0; n_w = 0; n_a2 = 0;
    cyc(1'b1, 1'b0, 15'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 15'h2000 + 15'(i), 1'b1);
      n_a += int'(s_rdy);
      n_w += int'(!s_wen);
      total++;
      if ({s_rdy, s_wen} !== {e_rdy, e_wen}) begin
        bad++;
        $display("FAIL busy_ctl cyc=%0d rdy/wen got=%b%b exp=%b%b", i, s_rdy, s_wen, e_rdy, e_wen);
      end
    end
    total++;
    if (n_a != DEPTH || n_w != 0 || s_rdy !== 1'b0) begin
      bad++;
      $display("FAIL busy_hold accepted=%0d writes=%0d rdy=%b exp %0d/0/0", n_a, n_w, s_rdy, DEPTH);
    end
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b1, 15'h2100 + 15'(i), 1'b0);
      n_a2 += int'(s_rdy);
      total++;
      if ({s_wen, s_addr, s_data, s_done} !== {e_wen, e_addr, e_data, e_done}) begin
        bad++;
        $display("FAIL busy_release cyc=%0d wen=%b addr=%h data=%h done=%b exp=%b %h %h %b",
                 i, s_wen, s_addr, s_data, s_done, e_wen, e_addr, e_data, e_done);
      end
      if (i < DEPTH) begin
        total++;
        if (s_wen !== 1'b0 || s_addr !== 20'(i) || s_data !== 16'h2000 + 16'(i)) begin
          bad++;
          $display("FAIL busy_drain n=%0d wen=%b addr=%h data=%h", i, s_wen, s_addr, s_data);
        end
      end
    end
    total++;
    if (n_a2 != TOTAL - DEPTH) begin
      bad++;
      $display("FAIL busy_resume accepted=%0d exp=%0d", n_a2, TOTAL - DEPTH);
    end
  endtask

  task automatic test_restart();
    int n_w, k;
    logic seen;
    n_w = 0; k = 0; seen = 1'b0;
    cyc(1'b1, 1'b0, 15'h0, 1'b0);
    for (int i = 0; i < 20 && n_w < 3; i++) begin
      cyc(1'b0, 1'b1, 15'h0100 + 15'(k), 1'b0);
      k++;
      n_w += int'(!s_wen);
    end
    for (int i = 0; i < 10 && m_q.size() < DEPTH; i++) begin
      cyc(1'b0, 1'b1, 15'h0100 + 15'(k), 1'b1);
      k++;
    end
    total++;
    if (n_w != 3 || m_q.size() != DEPTH || o_pix_ready !== 1'b0) begin
      bad++;
      $display("FAIL restart_setup writes=%0d fill=%0d rdy=%b exp 3/%0d/0", n_w, m_q.size(), o_pix_ready, DEPTH);
    end
    cyc(1'b1, 1'b1, 15'h0155, 1'b0);
    total++;
    if ({s_rdy, s_wen} !== 2'b01) begin
      bad++;
      $display("FAIL restart_edge rdy/wen got=%b%b exp=01", s_rdy, s_wen);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 15'h0600 + 15'(i), 1'b0);
      total++;
      if ({s_rdy, s_wen, s_done, s_addr, s_data} !== {e_rdy, e_wen, e_done, e_addr, e_data}) begin
        bad++;
        $display("FAIL restart_run cyc=%0d rdy=%b wen=%b done=%b addr=%h data=%h exp=%b %b %b %h %h",
                 i, s_rdy, s_wen, s_done, s_addr, s_data, e_rdy, e_wen, e_done, e_addr, e_data);
      end
      if (!s_wen && !seen) begin
        seen = 1'b1;
        total++;
        if (s_addr !== 20'h0 || s_data !== 16'h0600) begin
          bad++;
          $display("FAIL restart_first addr=%h data=%h exp 0/0600", s_addr, s_data);
        end
      end
      if (!s_wen && s_data[15:8] == 8'h01) begin
        total++; bad++;
        $display("FAIL restart_stale old pixel %h written at %h", s_data, s_addr);
      end
    end
  endtask

  task automatic test_start_on_done();
    logic got_done;
    got_done = 1'b0;
    cyc(1'b1, 1'b0, 15'h0, 1'b0);
    for (int i = 0; i < TOTAL; i++) cyc(1'b0, 1'b1, 15'h2A00 + 15'(i), 1'b0);
    for (int i = 0; i < 10 && !got_done; i++) begin
      if (s_done) got_done = 1'b1;
      else        cyc(1'b0, 1'b0, 15'h0, 1'b0);
    end
    total++;
    if (!got_done || s_wen !== 1'b0 || s_addr !== 20'(TOTAL-1)) begin
      bad++;
      $display("FAIL done_wait done=%b wen=%b addr=%h exp 1/0/%0d", got_done, s_wen, s_addr, TOTAL-1);
    end
    cyc(1'b1, 1'b0, 15'h0, 1'b0);
    total++;
    if ({s_done, s_wen} !== 2'b01) begin
      bad++;
      $display("FAIL done_restart done/wen got=%b%b exp=01", s_done, s_wen);
    end
    cyc(1'b0, 1'b1, 15'h3300, 1'b0);
    total++;
    if (s_rdy !== 1'b1) begin
      bad++;
      $display("FAIL done_ready rdy=%b exp=1", s_rdy);
    end
    cyc(1'b0, 1'b0, 15'h0, 1'b0);
    total++;
    if ({s_wen, s_addr, s_data} !== {1'b0, 20'h0, 16'h3300}) begin
      bad++;
      $display("FAIL done_next wen=%b addr=%h data=%h exp 0/0/3300", s_wen, s_addr, s_data);
    end
  endtask

  task automatic test_random();
    logic fs, vld, busy;
    for (int i = 0; i < 400; i++) begin
      fs   = ($urandom_range(0, 59) == 0);
      vld  = ($urandom_range(0, 3) != 0);
      busy = ($urandom_range(0, 2) == 0);
      cyc(fs, vld, 15'(32'($urandom)), busy);
      total++;
      if ({s_rdy, s_wen, s_done, s_addr, s_data} !== {e_rdy, e_wen, e_done, e_addr, e_data}) begin
        bad++;
        $display("FAIL random cyc=%0d rdy=%b wen=%b done=%b addr=%h data=%h exp=%b %b %b %h %h",
                 i, s_rdy, s_wen, s_done, s_addr, s_data, e_rdy, e_wen, e_done, e_addr, e_data);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_frame_start = 1'b0; i_pix_valid = 1'b0; i_pix_data = '0; i_rd_busy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_idle();
    test_back_to_back();
    test_busy_stall();
    test_restart();
    test_start_on_done();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
